// File: rtl/huffman_encoder_fsm.sv
// Huffman encoder for signed 4-bit symbols: packs variable-length codes into a
// bit accumulator and streams them out oldest-first as chunks of up to 4 bits.
module huffman_encoder_fsm #(
  parameter int MAX_CODE = 9,
  parameter int ACC_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic signed [3:0] in_symbol,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [3:0]        out_data,
  output logic [2:0]        out_len,
  input  logic              out_ready,
  output logic [3:0]        bit_count,
  output logic              flush_done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state, state_n;

  logic [ACC_W-1:0]    acc, acc_n, keep_mask;
  logic [ACC_W:0]      keep_lim;
  logic [3:0]          bit_count_n, load_n, remain, add_n, code_len;
  logic [MAX_CODE-1:0] code;
  logic                out_valid_n, flush_done_n;
  logic [3:0]          out_data_n;
  logic [2:0]          out_len_n;
  logic                flush_pending, accept, can_load, load_full, load_part;

  always_comb begin
    code     = '0;
    code_len = 4'd0;
    case (in_symbol)
      4'b0000: begin code = MAX_CODE'(9'b000000000); code_len = 4'd1; end
      4'b0001: begin code = MAX_CODE'(9'b000000100); code_len = 4'd3; end
      4'b0010: begin code = MAX_CODE'(9'b000001100); code_len = 4'd4; end
      4'b0011: begin code = MAX_CODE'(9'b000011110); code_len = 4'd5; end
      4'b0100: begin code = MAX_CODE'(9'b000111111); code_len = 4'd6; end
      4'b0101: begin code = MAX_CODE'(9'b001111101); code_len = 4'd7; end
      4'b0110: begin code = MAX_CODE'(9'b001011001); code_len = 4'd7; end
      4'b0111: begin code = MAX_CODE'(9'b111110011); code_len = 4'd9; end
      4'b1111: begin code = MAX_CODE'(9'b000001110); code_len = 4'd4; end
      4'b1110: begin code = MAX_CODE'(9'b000001101); code_len = 4'd4; end
      4'b1101: begin code = MAX_CODE'(9'b000001010); code_len = 4'd4; end
      4'b1100: begin code = MAX_CODE'(9'b000010111); code_len = 4'd5; end
      4'b1011: begin code = MAX_CODE'(9'b000101101); code_len = 4'd6; end
      4'b1010: begin code = MAX_CODE'(9'b001011000); code_len = 4'd7; end
      4'b1001: begin code = MAX_CODE'(9'b011111000); code_len = 4'd8; end
      4'b1000: begin code = MAX_CODE'(9'b111110010); code_len = 4'd9; end
    endcase
  end

  // The oldest buffered bit sits at acc[bit_count-1]; bits above are always zero.
  always_comb begin
    flush_pending = (state == FLUSH);
    in_ready      = (bit_count <= 4'(ACC_W - MAX_CODE)) && !flush_pending;
    accept        = in_valid && in_ready;
    can_load      = !out_valid || out_ready;
    load_full     = can_load && (bit_count >= 4'd4);
    load_part     = can_load && flush_pending && (bit_count != 4'd0) && (bit_count < 4'd4);
    load_n        = load_full ? 4'd4 : (load_part ? bit_count : 4'd0);
    remain        = bit_count - load_n;
    add_n         = accept ? code_len : 4'd0;
    bit_count_n   = remain + add_n;
    keep_lim      = (ACC_W+1)'(1) << remain;
    keep_mask     = ACC_W'(keep_lim - (ACC_W+1)'(1));
    acc_n         = ((acc & keep_mask) << add_n) | (accept ? ACC_W'(code) : '0);

    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_len_n   = out_len;
    if (load_full) begin
      out_valid_n = 1'b1;
      out_data_n  = 4'(acc >> (bit_count - 4'd4));
      out_len_n   = 3'd4;
    end else if (load_part) begin
      out_valid_n = 1'b1;
      out_data_n  = 4'(acc);
      out_len_n   = 3'(bit_count);
    end else if (out_valid && out_ready) begin
      out_valid_n = 1'b0;
    end
  end

  // A flush with nothing buffered or pending completes immediately from IDLE.
  always_comb begin
    state_n      = state;
    flush_done_n = 1'b0;
    case (state)
      FLUSH: begin
        if (bit_count == 4'd0 && can_load) begin
          state_n      = IDLE;
          flush_done_n = 1'b1;
        end
      end
      default: begin
        if (flush) begin
          if (bit_count == 4'd0 && !out_valid && !accept) begin
            state_n      = IDLE;
            flush_done_n = 1'b1;
          end else begin
            state_n = FLUSH;
          end
        end else begin
          state_n = (bit_count_n == 4'd0) ? IDLE : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      bit_count  <= 4'd0;
      out_valid  <= 1'b0;
      out_data   <= 4'd0;
      out_len    <= 3'd0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      bit_count  <= bit_count_n;
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      out_len    <= out_len_n;
      flush_done <= flush_done_n;
    end
  end

endmodule

// File: tb/tb_huffman_encoder_fsm.sv
// Bench for huffman_encoder_fsm: a bit-queue model checked every cycle plus
// directed scenarios with hand-computed chunk sequences.
module tb_huffman_encoder_fsm;
  localparam int MAX_CODE = 9;
  localparam int ACC_W    = 12;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic signed [3:0] in_symbol;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic [3:0]        out_data;
  logic [2:0]        out_len;
  logic              out_ready;
  logic [3:0]        bit_count;
  logic              flush_done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  huffman_encoder_fsm #(.MAX_CODE(MAX_CODE), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_symbol(in_symbol),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_len(out_len), .out_ready(out_ready),
    .bit_count(bit_count), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: a queue of buffered bits (front = oldest) and the output register.
  bit         q[$];
  bit         m_valid, m_flush, m_fd, m_last_accept;
  logic [3:0] m_data;
  int         m_len;
  int         m_cnt;
  bit         m_acc, m_can, m_v0, m_f;
  logic [3:0] m_d;
  string      m_code;
  logic [6:0] dut_log[$];
  logic [6:0] exp_q[$];

  function automatic string code_str(input int s);
    case (s)
      0: return "0";          1: return "100";        2: return "1100";
      3: return "11110";      4: return "111111";     5: return "1111101";
      6: return "1011001";    7: return "111110011";  -1: return "1110";
      -2: return "1101";      -3: return "1010";      -4: return "10111";
      -5: return "101101";    -6: return "1011000";   -7: return "11111000";
      -8: return "111110010";
      default: return "";
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_valid = 0; m_data = 0; m_len = 0; m_flush = 0; m_fd = 0; m_last_accept = 0;
    end else begin
      m_cnt = q.size();
      m_v0  = m_valid;
      m_acc = in_valid && (m_cnt <= ACC_W - MAX_CODE) && !m_flush;
      m_can = !m_valid || out_ready;
      m_f   = 0;
      if (m_can && (m_cnt >= 4 || (m_flush && m_cnt > 0))) begin
        m_len = (m_cnt >= 4) ? 4 : m_cnt;
        m_d = 4'd0;
        for (int i = 0; i < m_len; i++) m_d = {m_d[2:0], q.pop_front()};
        m_data  = m_d;
        m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (m_flush) begin
        if (m_cnt == 0 && m_can) begin m_flush = 0; m_f = 1; end
      end else if (flush) begin
        if (m_cnt == 0 && !m_v0 && !m_acc) m_f = 1;
        else m_flush = 1;
      end
      if (m_acc) begin
        m_code = code_str(int'(in_symbol));
        for (int i = 0; i < m_code.len(); i++) q.push_back(m_code[i] == 8'h31);
      end
      m_fd = m_f;
      m_last_accept = m_acc;
    end
  end

  always @(posedge clk)
    if (reset && out_valid && out_ready) dut_log.push_back({out_data, out_len});

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_out_valid", out_valid, m_valid);
      if (m_valid) begin
        checkOutput("cyc_out_data", out_data, m_data);
        checkOutput("cyc_out_len", out_len, m_len);
      end
      checkOutput("cyc_bit_count", bit_count, q.size());
      checkOutput("cyc_in_ready", in_ready, (q.size() <= ACC_W - MAX_CODE) && !m_flush);
      checkOutput("cyc_flush_done", flush_done, m_fd);
    end
  end

  task automatic applyStimulus(input int sym, input bit valid, input bit fl, input bit rnd);
    int n = 0;
    in_symbol = 4'(sym);
    in_valid  = valid;
    flush     = fl;
    do begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
      flush = 0;
      n++;
    end while (valid && !m_last_accept && n < 60);
    if (valid) checkOutput("accept_timeout", m_last_accept, 1);
    in_valid = 0;
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
    end
  endtask

  task automatic waitFlushDone(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i <= budget; i++) begin
      if (flush_done) begin seen = 1; break; end
      @(posedge clk); #2;
    end
    checkOutput(name, seen, 1);
  endtask

  task automatic checkChunks(input string name, input int start);
    int got = dut_log.size() - start;
    checkOutput({name, "_count"}, got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got; i++)
      checkOutput($sformatf("%s_%0d", name, i), dut_log[start + i], exp_q[i]);
  endtask

  initial begin
    int start;
    int bits;
    reset = 0; in_valid = 0; in_symbol = 0; flush = 0; out_ready = 1;
    @(posedge clk); #2;
    cmp_en = 1;
    @(posedge clk); #2;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_bit_count", bit_count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_flush_done", flush_done, 0);
    reset = 1;
    idle(1, 0);

    $display("[TB] symbol 7 then flush");
    start = dut_log.size();
    applyStimulus(7, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    waitFlushDone("sym7_flush_done", 12);
    exp_q.delete(); exp_q.push_back({4'b1111, 3'd4}); exp_q.push_back({4'b1001, 3'd4});
    exp_q.push_back({4'b0001, 3'd1});
    checkChunks("sym7", start);
    checkOutput("sym7_bit_count", bit_count, 0);
    idle(2, 0);

    $display("[TB] four zeros");
    start = dut_log.size();
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);
    idle(4, 0);
    exp_q.delete(); exp_q.push_back({4'b0000, 3'd4});
    checkChunks("zeros", start);
    checkOutput("zeros_bit_count", bit_count, 0);

    $display("[TB] symbols 1,2 then flush");
    start = dut_log.size();
    applyStimulus(1, 1, 0, 0);
    applyStimulus(2, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    waitFlushDone("s12_flush_done", 12);
    exp_q.delete(); exp_q.push_back({4'b1001, 3'd4}); exp_q.push_back({4'b0100, 3'd3});
    checkChunks("s12", start);
    idle(2, 0);

    $display("[TB] symbol -8 with stall");
    start = dut_log.size();
    out_ready = 0;
    applyStimulus(-8, 1, 0, 0);
    idle(1, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_out_data", out_data, 4'b1111);
      checkOutput("stall_bit_count", bit_count, 5);
      checkOutput("stall_in_ready", in_ready, 0);
      idle(1, 0);
    end
    out_ready = 1;
    idle(2, 0);
    exp_q.delete(); exp_q.push_back({4'b1111, 3'd4}); exp_q.push_back({4'b1001, 3'd4});
    checkChunks("stall", start);
    checkOutput("stall_rel_bit_count", bit_count, 1);
    checkOutput("stall_rel_in_ready", in_ready, 1);
    applyStimulus(0, 0, 1, 0);
    waitFlushDone("stall_flush_done", 12);
    idle(2, 0);

    $display("[TB] reset during stall");
    out_ready = 0;
    applyStimulus(-8, 1, 0, 0);
    idle(3, 0);
    reset = 0;
    idle(1, 0);
    checkOutput("mrst_out_valid", out_valid, 0);
    checkOutput("mrst_bit_count", bit_count, 0);
    reset = 1;
    checkOutput("mrst_in_ready", in_ready, 1);
    start = dut_log.size();
    out_ready = 1;
    idle(4, 0);
    checkOutput("mrst_no_stale", dut_log.size() - start, 0);

    $display("[TB] flush while idle");
    start = dut_log.size();
    applyStimulus(0, 0, 1, 0);
    checkOutput("idle_flush_done", flush_done, 1);
    idle(1, 0);
    checkOutput("idle_flush_done_pulse", flush_done, 0);
    idle(2, 0);
    checkOutput("idle_flush_no_chunk", dut_log.size() - start, 0);

    $display("[TB] flush with symbol 3 in same cycle");
    start = dut_log.size();
    applyStimulus(3, 1, 1, 0);
    waitFlushDone("same_flush_done", 12);
    exp_q.delete(); exp_q.push_back({4'b1111, 3'd4}); exp_q.push_back({4'b0000, 3'd1});
    checkChunks("same", start);
    idle(2, 0);

    $display("[TB] all symbols with random backpressure");
    start = dut_log.size();
    for (int s = -8; s <= 7; s++) applyStimulus(s, 1, 0, 1);
    idle(5, 1);
    out_ready = 1;
    applyStimulus(0, 0, 1, 0);
    waitFlushDone("all_flush_done", 40);
    bits = 0;
    for (int i = start; i < dut_log.size(); i++) bits += int'(dut_log[i][2:0]);
    checkOutput("all_total_bits", bits, 89);
    checkOutput("all_bit_count", bit_count, 0);
    idle(2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/huffman_encoder_fsm.md
HUFFMAN_ENCODER_FSM -- requirements
Module: huffman_encoder_fsm

Interface
REQ-001 Parameter MAX_CODE, default 9, SHALL be the longest Huffman code length in bits.
REQ-002 Parameter ACC_W, default 12, SHALL be the accumulator depth in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_valid  input  1  SHALL mark a valid symbol on in_symbol.
REQ-006 in_symbol  input  4 (signed)  SHALL carry the symbol to encode, range -8..7.
REQ-007 in_ready  output  1  SHALL indicate the block accepts a symbol this cycle.
REQ-008 flush  input  1  SHALL be a one-cycle request to drain all buffered bits, including a partial final chunk.
REQ-009 out_valid  output  1  SHALL mark a valid chunk on out_data/out_len.
REQ-010 out_data  output  4  SHALL carry code bits: LSB = newest bit; oldest bit at position out_len-1; unused upper bits 0.
REQ-011 out_len  output  3  SHALL give the number of valid bits in out_data (1-4).
REQ-012 out_ready  input  1  SHALL indicate the downstream decoder takes the chunk this cycle.
REQ-013 bit_count  output  4  SHALL report accumulator occupancy (0..ACC_W).
REQ-014 flush_done  output  1  SHALL pulse for one cycle when a flush completes.

Function
REQ-015 Code table (MSB sent first): 0=0; 1=100; 2=1100; 3=11110; 4=111111; 5=1111101; 6=1011001; 7=111110011; -1=1110; -2=1101; -3=1010; -4=10111; -5=101101; -6=1011000; -7=11111000; -8=111110010.
REQ-016 in_ready SHALL equal (bit_count <= ACC_W-MAX_CODE) AND NOT flush_pending; a symbol is accepted when in_valid AND in_ready at a rising edge.
REQ-017 An accepted symbol's code SHALL be appended behind all previously buffered bits; codes SHALL be packed across symbol boundaries with no padding.
REQ-018 Output handshake: a chunk transfers when out_valid AND out_ready; while out_valid=1 and out_ready=0, out_data and out_len SHALL hold stable.
REQ-019 The output register SHALL load when (out_valid=0 OR out_ready=1) and either bit_count>=4 (load the 4 oldest bits, out_len=4) or flush_pending=1 with bit_count in 1..3 (load all remaining bits, out_len=bit_count).
REQ-020 When no load occurs and the current chunk transfers, out_valid SHALL drop at the next edge.
REQ-021 Latency: the first chunk from a symbol accepted at edge N with bit_count reaching >=4 SHALL be valid after edge N+1.
REQ-022 bit_count SHALL update per edge as bit_count - (bits loaded) + (code length accepted); it SHALL never exceed ACC_W.
REQ-023 States: IDLE (bit_count=0, no flush pending); RUN (bit_count>0, no flush pending); FLUSH (flush_pending=1).
REQ-024 Transitions: IDLE->RUN on symbol accept; RUN->IDLE when bit_count reaches 0; IDLE/RUN->FLUSH on flush=1; FLUSH->IDLE when bit_count=0 and the last chunk has transferred, pulsing flush_done on that edge.
REQ-025 flush in IDLE with out_valid=0 SHALL pulse flush_done after the next edge and emit no chunk.
REQ-026 flush and in_valid in the same cycle: the symbol SHALL be accepted if in_ready=1 and included in the flush.
REQ-027 flush while in FLUSH SHALL be ignored.
REQ-028 A symbol of length 1-3 with no flush SHALL remain buffered until more bits arrive.

Reset
REQ-029 While reset=0 at an edge: out_valid=0, out_data=0, out_len=0, bit_count=0, flush_done=0, state=IDLE, flush_pending=0, accumulator cleared.
REQ-030 Reset asserted mid-operation SHALL discard buffered bits and any pending chunk; in_ready=1 on the first cycle after release.

Verification
REQ-031 Reset: hold reset=0 for 2 cycles -> out_valid=0, bit_count=0, in_ready=1, flush_done=0.
REQ-032 Symbol 7, out_ready=1, then flush -> chunks (4'b1111,4), (4'b1001,4), (4'b0001,1); then flush_done pulse; bit_count=0.
REQ-033 Symbol 0 four times, no flush -> exactly one chunk (4'b0000,4); bit_count=0 afterwards.
REQ-034 Symbol 1 then 2, then flush -> (4'b1001,4), then (3'b100 as 4'b0100,3), then flush_done.
REQ-035 Symbol -8 with out_ready=0 -> out_valid=1 with out_data=4'b1111 stable for all stalled cycles; bit_count=5; in_ready=0. Release out_ready -> (4'b1001,4) follows; bit_count=1; in_ready=1.
REQ-036 Assert reset=0 during the REQ-035 stall -> out_valid=0 and bit_count=0 next cycle; no stale chunk after release.
